// File: rtl/shift_arbiter_pkg.sv
// Purpose: shared types and constants for the shift_arbiter block.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package shift_arbiter_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } arb_state_t;

  // 1-bit requester index (0 or 1)
  typedef logic req_id_t;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/shift_left_logical.sv
// Purpose: combinational logical left shift, zero-filled, excess bits dropped.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: in (N) operand, shamt ($clog2(N)) shift amount, out (N) result.
module shift_left_logical #(
  parameter int N = 32
) (
  input  logic [N-1:0]         in,
  input  logic [$clog2(N)-1:0] shamt,
  output logic [N-1:0]         out
);

  assign out = in << shamt;

endmodule

// File: rtl/shift_arbiter.sv
// Purpose: round-robin share of one left shifter between two valid/ready requesters.
// Latency: 1 cycle, result registered with its requester tag on the accept edge.
// Backpressure: result held until out_ready; a pop and a new accept may share an edge.
// Ports: clk, rst (async active-low); req0_*/req1_* valid/ready/in/shamt request
//        channels; out_valid/out_ready/out/out_id result channel.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [N-1:0]         req0_in,
  input  logic [$clog2(N)-1:0] req0_shamt,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [N-1:0]         req1_in,
  input  logic [$clog2(N)-1:0] req1_shamt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out,
  output logic                 out_id
);

  localparam int SW = $clog2(N);

  arb_state_t     state, state_nxt;
  req_id_t        last_grant;
  req_id_t        winner;
  logic           can_accept;
  logic           accept;
  logic [N-1:0]   sh_in;
  logic [SW-1:0]  sh_amt;
  logic [N-1:0]   sh_out;

  // Winner selection: a lone requester wins; on conflict, the one not
  // granted last time wins.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = ~last_grant;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
  end

  // Pass-through slot: a held result that is being popped frees the register
  // for a new accept on the same edge. rst gates the grant path so readies
  // drop the moment reset asserts.
  assign can_accept = rst && ((state == S_IDLE) || out_ready);
  assign req0_ready = can_accept && req0_valid && (winner == 1'b0);
  assign req1_ready = can_accept && req1_valid && (winner == 1'b1);
  assign accept     = req0_ready || req1_ready;

  assign sh_in  = winner ? req1_in    : req0_in;
  assign sh_amt = winner ? req1_shamt : req0_shamt;

  shift_left_logical #(.N(N)) u_shl (
    .in    (sh_in),
    .shamt (sh_amt),
    .out   (sh_out)
  );

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = S_HOLD;
    end else if ((state == S_HOLD) && out_ready) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Reset value 1 makes requester 0 win the first conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      out        <= '0;
      out_id     <= 1'b0;
    end else if (accept) begin
      last_grant <= winner;
      out        <= sh_out;
      out_id     <= winner;
    end
  end

  assign out_valid = (state == S_HOLD);

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_in = '0, req1_in = '0;
  logic [4:0]  req0_shamt = '0, req1_shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] dout;
  logic        out_id;

  int total = 0;
  int bad   = 0;

  shift_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_in    (req0_in),
    .req0_shamt (req0_shamt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_in    (req1_in),
    .req1_shamt (req1_shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (dout),
    .out_id     (out_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_hold = 1'b0;
  logic [31:0] m_out  = '0;
  bit          m_id   = 1'b0;
  bit          m_last = 1'b1;

  // Which requester is granted right now: -1 when none.
  function automatic int pick();
    if (rst !== 1'b1) return -1;
    if (m_hold && !out_ready) return -1;
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    int g;
    if (!rst) begin
      m_hold = 1'b0; m_out = '0; m_id = 1'b0; m_last = 1'b1;
    end else begin
      g = pick();
      if (g == 0) begin
        m_out = req0_in << req0_shamt; m_id = 1'b0; m_last = 1'b0; m_hold = 1'b1;
      end else if (g == 1) begin
        m_out = req1_in << req1_shamt; m_id = 1'b1; m_last = 1'b1; m_hold = 1'b1;
      end else if (m_hold && out_ready) begin
        m_hold = 1'b0;
      end
    end
  end

  // Compare process: every falling edge, DUT vs model.
  always @(negedge clk) begin
    int g;
    g = pick();
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_hold});
    chk("m_req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
    chk("m_req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
    if (m_hold) begin
      chk("m_out", dout, m_out);
      chk("m_out_id", {31'd0, out_id}, {31'd0, m_id});
    end
    if (!rst) chk("m_out_rst", dout, 32'h0);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", dout, 32'h0);
    chk("rst_out_id", {31'd0, out_id}, 32'd0);
    step();
    rst = 1'b1;

    // Single requester 0: 1 << 5
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_in = 32'h1; req0_shamt = 5'd5;
    #1;
    chk("t1_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("t1_req1_ready", {31'd0, req1_ready}, 32'd0);
    step();
    req0_valid = 1'b0;
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out", dout, 32'h20);
    chk("t1_out_id", {31'd0, out_id}, 32'd0);

    // Single requester 1, boundary shamt=31: 3 << 31
    req1_valid = 1'b1; req1_in = 32'h3; req1_shamt = 5'd31;
    step();
    req1_valid = 1'b0;
    chk("b31_out", dout, 32'h8000_0000);
    chk("b31_out_id", {31'd0, out_id}, 32'd1);

    // Fairness: both valid, grants 0,1,0,1
    req0_valid = 1'b1; req0_in = 32'h1; req0_shamt = 5'd1;
    req1_valid = 1'b1; req1_in = 32'h3; req1_shamt = 5'd4;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_req0_ready", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_req1_ready", {31'd0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      chk("rr_out", dout, (i % 2 == 0) ? 32'h2 : 32'h30);
      chk("rr_out_id", {31'd0, out_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Backpressure
    req1_valid = 1'b1; req1_in = 32'h8000_0001; req1_shamt = 5'd1;
    step();
    req1_valid = 1'b0; out_ready = 1'b0;
    req0_valid = 1'b1; req0_in = 32'hDEAD_BEEF; req0_shamt = 5'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out", dout, 32'h0000_0002);
      chk("bp_out_id", {31'd0, out_id}, 32'd1);
      chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("pp_req0_ready", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0; out_ready = 1'b0;
    chk("pp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("b0_out", dout, 32'hDEAD_BEEF);
    chk("pp_out_id", {31'd0, out_id}, 32'd0);

    // Reset mid-hold, both requesters valid
    req0_valid = 1'b1; req0_in = 32'h5; req0_shamt = 5'd2;
    req1_valid = 1'b1; req1_in = 32'h7; req1_shamt = 5'd3;
    #2;
    rst = 1'b0;
    #1;
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_out", dout, 32'h0);
    chk("mr_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("mr_req1_ready", {31'd0, req1_ready}, 32'd0);
    step();
    rst = 1'b1; out_ready = 1'b1;
    #1;
    chk("ar_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("ar_req1_ready", {31'd0, req1_ready}, 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("ar_out", dout, 32'h14);
    chk("ar_out_id", {31'd0, out_id}, 32'd0);
    step();

    // Idle for 5 cycles: nothing valid, nothing held
    for (int i = 0; i < 5; i++) begin
      chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
      chk("idle_req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("idle_req1_ready", {31'd0, req1_ready}, 32'd0);
      step();
    end
    // last grant was 0, so a conflict now goes to requester 1
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("idle_conf_req1", {31'd0, req1_ready}, 32'd1);
    chk("idle_conf_req0", {31'd0, req0_ready}, 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("idle_conf_out", dout, 32'h38);
    chk("idle_conf_id", {31'd0, out_id}, 32'd1);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Round-robin arbiter that time-shares one combinational `shift_left_logical` (N-bit `in`, `$clog2(N)`-bit `shamt`, N-bit `out`) between two requesters. Each requester offers an operand and a shift amount on a valid/ready channel. The block grants one requester, registers the shifted result with a requester tag, and holds it on a single output valid/ready channel until it is consumed. It sits between the ALU-side clients and the shared shifter, so no client needs its own barrel shifter.

## Interface
- `N`, default 32: data width. Power of two, ≥ 2.
- `clk` in, 1: sole clock, rising edge.
- `rst` in, 1: reset, asynchronous, active-low (asserted when 0).
- `req0_valid`, `req1_valid` in, 1: requester k offers an operation.
- `req0_ready`, `req1_ready` out, 1: requester k's operation is accepted this cycle.
- `req0_in`, `req1_in` in, N: operand.
- `req0_shamt`, `req1_shamt` in, `$clog2(N)`: left-shift amount.
- `out_valid` out, 1: result held.
- `out_ready` in, 1: consumer takes the result.
- `out` out, N: `in << shamt` of the granted operation, zero-filled.
- `out_id` out, 1: index of the requester that produced `out`.

## Operation
- FSM states: `S_IDLE` (no result held) and `S_HOLD` (result held, `out_valid`=1).
- The block can accept when `state==S_IDLE`, or when `state==S_HOLD && out_ready` (pass-through slot, which gives full throughput).
- Arbitration is combinational.
  - Only one requester valid: it wins.
  - Both valid: the requester that was not `last_grant` wins.
- `reqk_ready` = can-accept AND winner==k. At most one ready is high per cycle. Ready is never asserted to a requester whose valid is low.
- Mux: the winner's `in`/`shamt` drive the single `shift_left_logical` instance.
- Accept cycle (valid & ready for some k):
  - `out` ← shifter output.
  - `out_id` ← k.
  - `last_grant` ← k.
  - state → `S_HOLD`.
- `S_HOLD` with `out_ready` and no accept: state → `S_IDLE`. `out` and `out_id` keep their values (don't-care).
- `S_HOLD` without `out_ready`: everything holds. No new accepts.
- Arithmetic: pure logical left shift. `shamt`=0 passes through. Bits shifted past bit N-1 are discarded. There is no overflow flag.
- Requesters must hold `in`/`shamt` stable while valid and not ready. Only the value on the accept cycle matters.

## Timing
- Latency: accept at edge t, so `out_valid`=1 with the result visible after edge t (registered, 1 cycle).
- Throughput: 1 result per cycle while `out_ready`=1 and a requester is valid.
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=`S_IDLE`, `out_valid`=0, `out`=0, `out_id`=0.
  - `last_grant`=1, so requester 0 wins the first conflict.
- Reset mid-operation: a held result is dropped and not replayed. Both readies go low immediately because state is `S_IDLE` and the grant path is gated by `rst`.
- `out_valid` never drops without `out_ready` (AXI-style stability). `out`/`out_id` are stable while `out_valid && !out_ready`.
- Simultaneous pop and push: the old result is consumed and the new one is loaded on the same edge, and `out_valid` stays 1.
- Fairness: with both valid continuously and `out_ready`=1, grants alternate 0,1,0,1…

## Structure
- Package `shift_arbiter_pkg`:
  - `typedef enum logic {S_IDLE, S_HOLD} arb_state_t`
  - `typedef logic req_id_t` (1-bit requester index)
  - localparam `NUM_REQ`=2
- Sub-module: one `shift_left_logical #(.N(N))` instance, ports `.in`, `.shamt`, `.out`.
- Registers: `state`, `last_grant`, `out`, `out_id`. Everything else is combinational.

## Test plan
- Reset, then only req0 valid with `in`=1, `shamt`=5 and `out_ready`=1. Required: `req0_ready`=1 in that cycle; next cycle `out_valid`=1, `out`=32'h20, `out_id`=0.
- Both valid, req0 `in`=32'h1/`shamt`=1 and req1 `in`=32'h3/`shamt`=4, `out_ready`=1 held for 4 cycles. Required: grants go 0,1,0,1; outputs 32'h2, 32'h30, 32'h2, 32'h30 with `out_id` 0,1,0,1.
- Backpressure: accept req1 `in`=32'h8000_0001/`shamt`=1, then hold `out_ready`=0 for 3 cycles. Required: `out`=32'h0000_0002 stable, `out_valid`=1, both readies 0. Raise `out_ready` with req0 valid: pop and accept on the same edge.
- Boundary shifts: `shamt`=0 with `in`=32'hDEAD_BEEF gives 32'hDEAD_BEEF; `shamt`=31 with `in`=32'h3 gives 32'h8000_0000.
- Reset mid-hold: assert `rst`=0 while `out_valid`=1. Required: `out_valid`=0, `out`=0 immediately (asynchronous). After release, the first conflict goes to req0.
- Idle: no valids for 5 cycles. Required: `out_valid` stays 0, readies 0, `last_grant` unchanged.
